// File: rtl/vga_scanout.sv
// VGA timing generator and 4x-scaled framebuffer scanout.
// Addresses are combinational from the raster counters; colour/sync are registered one clock later.
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [7:0] x_data,
   output logic [7:0] y_data,
   input  logic [7:0] pixelData,
   output logic [3:0] vga_r,
   output logic [3:0] vga_g,
   output logic [3:0] vga_b,
   output logic       hsync,
   output logic       vsync,
   output logic       de,
   output logic       vblank,
   output logic       frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS_END  = HW'(H_VISIBLE);
   localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS_END  = VW'(V_VISIBLE);
   localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_vis;
   logic          v_vis;
   logic          h_wrap;
   logic          vis;

   assign h_vis  = (h_cnt < H_VIS_END);
   assign v_vis  = (v_cnt < V_VIS_END);
   assign vis    = h_vis && v_vis;
   assign h_wrap = (h_cnt == H_LAST);

   // Out-of-range addresses (160/120) make the framebuffer return black.
   assign x_data = h_vis ? 8'(h_cnt >> 2) : 8'd160;
   assign y_data = v_vis ? 8'(v_cnt >> 2) : 8'd120;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         de          <= 1'b0;
         vblank      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
         if (h_wrap) begin
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end
         // RGB332 widened to 4 bits per channel by replicating the top bits.
         vga_r       <= vis ? {pixelData[7:5], pixelData[7]} : 4'd0;
         vga_g       <= vis ? {pixelData[4:2], pixelData[4]} : 4'd0;
         vga_b       <= vis ? {pixelData[1:0], pixelData[1:0]} : 4'd0;
         hsync       <= !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
         vsync       <= !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));
         de          <= vis;
         vblank      <= !v_vis;
         frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// Randomized scoreboard bench for vga_scanout: a default-timing instance and a
// shortened-timing instance (so whole frames fit in a short run) share clock, reset and pixel data.
module tb_vga_scanout;

   // Shortened timing: 80 clocks per line, 230 lines per frame.
   localparam int SHV = 64, SHF = 4, SHS = 8, SHB = 4;
   localparam int SVV = 220, SVF = 3, SVS = 2, SVB = 5;
   localparam int DHV = 640, DHF = 16, DHS = 96, DHB = 48;
   localparam int DVV = 480, DVF = 10, DVS = 2, DVB = 33;
   localparam int S_LINE  = SHV + SHF + SHS + SHB;
   localparam int S_FRAME = S_LINE * (SVV + SVF + SVS + SVB);

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       hs;
      logic       vs;
      logic       de;
      logic       vb;
      logic       fs;
   } out_t;

   typedef struct packed {
      out_t d;
      out_t s;
   } exp_out_t;

   typedef struct packed {
      logic [7:0] xd;
      logic [7:0] yd;
      logic [7:0] xs;
      logic [7:0] ys;
   } exp_addr_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] pixelData;
   logic [7:0] x_d, y_d, x_s, y_s;
   logic [3:0] r_d, g_d, b_d, r_s, g_s, b_s;
   logic       hs_d, vs_d, de_d, vb_d, fs_d;
   logic       hs_s, vs_s, de_s, vb_s, fs_s;

   exp_out_t  exp_q[$];
   exp_addr_t addr_q[$];
   int        n_cmp  = 0;
   int        n_fail = 0;
   int        n_cyc  = 0;

   vga_scanout dut (
      .clk(clk), .rst_n(rst_n), .x_data(x_d), .y_data(y_d), .pixelData(pixelData),
      .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .hsync(hs_d), .vsync(vs_d),
      .de(de_d), .vblank(vb_d), .frame_start(fs_d)
   );

   vga_scanout #(
      .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
   ) dut_s (
      .clk(clk), .rst_n(rst_n), .x_data(x_s), .y_data(y_s), .pixelData(pixelData),
      .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .hsync(hs_s), .vsync(vs_s),
      .de(de_s), .vblank(vb_s), .frame_start(fs_s)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raster position is just the cycle count since reset release.
   function automatic out_t model_out(input int n, input logic [7:0] pix,
                                      input int hv, input int hf, input int hsw, input int hb,
                                      input int vv, input int vf, input int vsw, input int vb);
      int   ht, vt, h, v, r3, g3, b2;
      out_t o;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      h  = n % ht;
      v  = (n / ht) % vt;
      r3 = int'(pix) / 32;
      g3 = (int'(pix) / 4) % 8;
      b2 = int'(pix) % 4;
      o.de = (h < hv) && (v < vv);
      o.r  = o.de ? 4'(r3 * 2 + r3 / 4) : 4'd0;
      o.g  = o.de ? 4'(g3 * 2 + g3 / 4) : 4'd0;
      o.b  = o.de ? 4'(b2 * 5) : 4'd0;
      o.hs = !((h >= hv + hf) && (h < hv + hf + hsw));
      o.vs = !((v >= vv + vf) && (v < vv + vf + vsw));
      o.vb = (v >= vv);
      o.fs = (h == 0) && (v == 0);
      return o;
   endfunction

   function automatic logic [15:0] model_addr(input int n, input int hv, input int ht,
                                              input int vv, input int vt);
      int h, v, x, y;
      h = n % ht;
      v = (n / ht) % vt;
      x = (h < hv) ? h / 4 : 160;
      y = (v < vv) ? v / 4 : 120;
      return {8'(x), 8'(y)};
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, n_cyc, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " x_d"}, 16'(x_d), 16'd0);
      chk({tag, " y_d"}, 16'(y_d), 16'd0);
      chk({tag, " x_s"}, 16'(x_s), 16'd0);
      chk({tag, " y_s"}, 16'(y_s), 16'd0);
      chk({tag, " rgb_d"}, 16'({r_d, g_d, b_d}), 16'd0);
      chk({tag, " rgb_s"}, 16'({r_s, g_s, b_s}), 16'd0);
      chk({tag, " flags_d"}, 16'({hs_d, vs_d, de_d, vb_d, fs_d}), 16'b11000);
      chk({tag, " flags_s"}, 16'({hs_s, vs_s, de_s, vb_s, fs_s}), 16'b11000);
   endtask

   // Driver: one pixel per falling edge, expectations pushed for both instances.
   task automatic drive_one();
      logic [7:0] pix;
      int         h;
      exp_out_t   eo;
      logic [15:0] ad, as_;
      h = n_cyc % 800;
      if (n_cyc < 4)                 pix = 8'hE0;
      else if (n_cyc < 8)            pix = 8'h1F;
      else if (h >= 636 && h < 644)  pix = 8'h1F;
      else                           pix = 8'($urandom_range(0, 255));
      pixelData = pix;
      eo.d = model_out(n_cyc, pix, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB);
      eo.s = model_out(n_cyc, pix, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB);
      exp_q.push_back(eo);
      ad  = model_addr(n_cyc, DHV, DHV + DHF + DHS + DHB, DVV, DVV + DVF + DVS + DVB);
      as_ = model_addr(n_cyc, SHV, S_LINE, SVV, SVV + SVF + SVS + SVB);
      addr_q.push_back({ad, as_});
      n_cyc++;
   endtask

   task automatic run_cycles(input int count);
      for (int i = 0; i < count; i++) begin
         @(negedge clk);
         drive_one();
      end
   endtask

   // Monitor: registered outputs one clock after the address was presented.
   always @(posedge clk) begin
      #1;
      if (rst_n && exp_q.size() > 0) begin
         exp_out_t e;
         e = exp_q.pop_front();
         chk("rgb_d",   16'({r_d, g_d, b_d}), 16'({e.d.r, e.d.g, e.d.b}));
         chk("flags_d", 16'({hs_d, vs_d, de_d, vb_d, fs_d}),
             16'({e.d.hs, e.d.vs, e.d.de, e.d.vb, e.d.fs}));
         chk("rgb_s",   16'({r_s, g_s, b_s}), 16'({e.s.r, e.s.g, e.s.b}));
         chk("flags_s", 16'({hs_s, vs_s, de_s, vb_s, fs_s}),
             16'({e.s.hs, e.s.vs, e.s.de, e.s.vb, e.s.fs}));
      end
   end

   // Monitor: combinational framebuffer address in the cycle it is driven.
   always @(negedge clk) begin
      #1;
      if (rst_n && addr_q.size() > 0) begin
         exp_addr_t a;
         a = addr_q.pop_front();
         chk("addr_d", {x_d, y_d}, {a.xd, a.yd});
         chk("addr_s", {x_s, y_s}, {a.xs, a.ys});
      end
   end

   initial begin
      rst_n     = 1'b0;
      pixelData = 8'hE0;
      repeat (3) @(negedge clk);
      check_reset("reset_hold");

      @(negedge clk);
      rst_n = 1'b1;
      drive_one();
      // One full short frame plus two lines, then on to line 200 of the next frame.
      run_cycles(S_FRAME + 2 * S_LINE - 1);
      run_cycles(S_FRAME + 200 * S_LINE + 37 - n_cyc);

      // Asynchronous reset mid-frame, asserted between clock edges.
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("async_reset");
      @(negedge clk);
      check_reset("reset_mid");
      @(negedge clk);
      rst_n = 1'b1;
      n_cyc = 0;
      drive_one();
      run_cycles(2000);

      @(posedge clk);
      #3;
      chk("exp_q_drained", 16'(exp_q.size()), 16'd0);
      chk("addr_q_drained", 16'(addr_q.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
